// File: rtl/mul32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier controller.
package mul32_pkg;

   localparam int OP_W      = 32;
   localparam int LANE_W    = 8;
   localparam int NUM_LANES = 4;
   localparam int NUM_PP    = 16;
   localparam int IDX_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

endpackage

// File: rtl/dadda8.sv
// 8x8 unsigned multiplier shared by the sequential controller; the partial-product
// rows are summed here and the reduction tree is left to synthesis.
module dadda8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p + ({8'b0, a} << i);
      end
   end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 unsigned multiplier: one dadda8 walks all 16 byte-pair products.
// Optional MUL32_ZERO_SKIP_EN finishes in one cycle when either operand is zero.
module mul32_seq_ctrl
   import mul32_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [OP_W-1:0]     a,
   input  logic [OP_W-1:0]     b,
   output logic                busy,
   output logic                done,
   output logic [2*OP_W-1:0]   product
);

   state_t                                state;
   logic [NUM_LANES-1:0][LANE_W-1:0]      a_reg;
   logic [NUM_LANES-1:0][LANE_W-1:0]      b_reg;
   logic [IDX_W-1:0]                      idx;
   logic [2*OP_W-1:0]                     acc;
   logic [LANE_W-1:0]                     a_byte;
   logic [LANE_W-1:0]                     b_byte;
   logic [2*LANE_W-1:0]                   pp;
   logic [2:0]                            lane_sum;
   logic [5:0]                            shamt;
   logic [2*OP_W-1:0]                     acc_next;

   // Low idx bits walk A bytes, high bits walk B bytes; weight is the sum of both lanes.
   assign a_byte   = a_reg[idx[1:0]];
   assign b_byte   = b_reg[idx[3:2]];
   assign lane_sum = {1'b0, idx[1:0]} + {1'b0, idx[3:2]};
   assign shamt    = {lane_sum, 3'b000};
   assign acc_next = acc + ({{(2*OP_W-2*LANE_W){1'b0}}, pp} << shamt);

   dadda8 u_dadda8 (
      .a (a_byte),
      .b (b_byte),
      .p (pp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         idx     <= '0;
         acc     <= '0;
         product <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
               if (start) begin
                  a_reg <= a;
                  b_reg <= b;
                  acc   <= '0;
                  idx   <= '0;
`ifdef MUL32_ZERO_SKIP_EN
                  if ((a == '0) || (b == '0)) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     product <= '0;
                  end else begin
                     state <= MUL;
                     busy  <= 1'b1;
                  end
`else
                  state <= MUL;
                  busy  <= 1'b1;
`endif
               end
            end
            MUL: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NUM_PP - 1)) begin
                  product <= acc_next;
                  state   <= DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
